// File: rtl/asym_push_packer_if.sv
// Handshake bundle between the narrow-word producer, the asym_push_packer,
// and the wide-word FIFO it feeds. The slave modport is the packer's view.
interface asym_push_packer_if #(
  parameter int in_width  = 8,
  parameter int out_width = 16
);
  logic                 push_req_n;
  logic                 flush_n;
  logic [in_width-1:0]  data_in;
  logic                 fifo_full;
  logic                 push_wd_n;
  logic [out_width-1:0] data_out;
  logic                 inbuf_full;
  logic                 part_wd;
  logic                 push_error;

  modport master (
    output push_req_n, flush_n, data_in, fifo_full,
    input  push_wd_n, data_out, inbuf_full, part_wd, push_error
  );

  modport slave (
    input  push_req_n, flush_n, data_in, fifo_full,
    output push_wd_n, data_out, inbuf_full, part_wd, push_error
  );
endinterface

// File: rtl/asym_push_packer.sv
// asym_push_packer: packs K = out_width/in_width narrow sub-words into one wide
// word and presents it (combinationally, with an active-low push strobe) to a
// downstream wide FIFO. A flush pushes a partially filled word, padded with
// all-zeros or all-ones. Pushing while the FIFO is full raises push_error,
// either sticky or as a one-cycle pulse.
// Optional feature: define ASYM_PACKER_WDCNT_EN to add the wd_count output,
// a wrapping 16-bit count of wide words actually accepted by the FIFO.
module asym_push_packer #(
  parameter int in_width    = 8,
  parameter int out_width   = 16,
  parameter int err_mode    = 0,
  parameter int byte_order  = 0,
  parameter int flush_value = 0
) (
  input  logic                clk_push,
  input  logic                rst_push,
  asym_push_packer_if.slave   bus
`ifdef ASYM_PACKER_WDCNT_EN
  ,
  output logic [15:0]         wd_count
`endif
);

  localparam int K  = out_width / in_width;
  localparam int CW = $clog2(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);
  localparam logic [in_width-1:0] PAD =
    (flush_value != 0) ? {in_width{1'b1}} : {in_width{1'b0}};

  // Sub-word count and the K-1 holding slots; the final slot of a word is
  // never stored, it is taken straight from data_in on the completing push.
  logic [CW-1:0]       cnt_p1;
  logic [CW-1:0]       cnt_d;
  logic [in_width-1:0] slot_p1 [K-1];
  logic                err_p1;
  logic                err_d;

  logic                push;
  logic                flush;
  logic                complete;
  logic                flush_part;
  logic                wd_push;
  logic                err_event;
  logic                slot_we;
  logic [CW-1:0]       slot_idx;
  logic [in_width-1:0] slot_v;
  logic [out_width-1:0] word;

  // Drop sub-word v into slot idx of w according to the packing order.
  function automatic logic [out_width-1:0] place_slot(
    input logic [out_width-1:0] w,
    input int                   idx,
    input logic [in_width-1:0]  v
  );
    logic [out_width-1:0] r;
    r = w;
    if (byte_order == 0) r[out_width-1-idx*in_width -: in_width] = v;
    else                 r[idx*in_width +: in_width] = v;
    return r;
  endfunction

  // Decode this cycle's request: completing push, partial flush, error event.
  always_comb begin
    push       = ~bus.push_req_n;
    flush      = ~bus.flush_n;
    complete   = push && (cnt_p1 == LAST);
    flush_part = flush && (cnt_p1 != '0) && !complete;
    wd_push    = (complete || flush_part) && !rst_push;
    err_event  = wd_push && bus.fifo_full;
    slot_we    = push && !complete;
    slot_idx   = flush_part ? '0 : cnt_p1;
  end

  // Next sub-word count; a flush+push restarts a fresh word holding data_in.
  always_comb begin
    cnt_d = cnt_p1;
    if (complete)                 cnt_d = '0;
    else if (push && flush_part)  cnt_d = CW'(1);
    else if (push)                cnt_d = cnt_p1 + CW'(1);
    else if (flush_part)          cnt_d = '0;
  end

  // Next error flag: accumulate (sticky) or mirror the event (pulse).
  always_comb begin
    if (err_mode != 0) err_d = err_event;
    else               err_d = err_p1 | err_event;
  end

  // Control state: sub-word count and error flag.
  always_ff @(posedge clk_push) begin
    if (rst_push) begin
      cnt_p1 <= '0;
      err_p1 <= 1'b0;
    end else begin
      cnt_p1 <= cnt_d;
      err_p1 <= err_d;
    end
  end

  // Holding slots: capture data_in into the addressed slot on a non-completing push.
  always_ff @(posedge clk_push) begin
    if (rst_push) begin
      for (int i = 0; i < K - 1; i++) slot_p1[i] <= '0;
    end else if (slot_we) begin
      for (int i = 0; i < K - 1; i++) begin
        if (slot_idx == CW'(i)) slot_p1[i] <= bus.data_in;
      end
    end
  end

  // Assemble the outgoing word: held slots, then data_in or pad in the last slot.
  always_comb begin
    word   = '0;
    slot_v = PAD;
    for (int i = 0; i < K - 1; i++) begin
      slot_v = (i < int'(cnt_p1)) ? slot_p1[i] : PAD;
      word   = place_slot(word, i, slot_v);
    end
    slot_v = complete ? bus.data_in : PAD;
    word   = place_slot(word, K - 1, slot_v);
  end

  assign bus.push_wd_n  = ~wd_push;
  assign bus.data_out   = word;
  assign bus.inbuf_full = (cnt_p1 == LAST);
  assign bus.part_wd    = (cnt_p1 != '0);
  assign bus.push_error = err_p1;

`ifdef ASYM_PACKER_WDCNT_EN
  logic [15:0] wdc_p1;

  // Count wide words the FIFO actually took; wraps naturally at 16 bits.
  always_ff @(posedge clk_push) begin
    if (rst_push)                         wdc_p1 <= '0;
    else if (wd_push && !bus.fifo_full)   wdc_p1 <= wdc_p1 + 16'd1;
  end

  assign wd_count = wdc_p1;
`endif

endmodule
